mdu_seq_ctrl: RTL

- Multicycle multiply/divide sequencer for the MIPS EX stage. Executes MULT, MULTU, DIV and DIVU on 32-bit operands S and T, one bit per cycle.
- Owns the architectural HI/LO result registers.
- Drives a stall request to the pipeline hazard unit while an operation is in flight.
- Replaces the single-cycle combinational product path so timing closes at the pipeline clock.

---
 rtl/mdu_pkg.sv | 21 ++
 rtl/mdu_iter_core.sv | 61 ++++++
 rtl/mdu_seq_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings,
// controller states, default operand width and the divide-by-zero quotient.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam logic [MDU_WIDTH-1:0] DIV0_QUOT = '1;

endpackage

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide.
// Ports: clk, reset (sync, high); load captures a_in (multiplier or
// dividend, into lo) and b_in (multiplicand or divisor); step advances one
// iteration, sub selects divide; hi/lo expose the working pair.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH:0]   hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] b_r;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the {hi,lo} pair right; the carry lands in hi[WIDTH-1].
    assign sum = hi_r + (lo_r[0] ? {1'b0, b_r} : '0);

    // Divide: shift the next dividend bit into the partial remainder and
    // keep the difference only when it does not borrow.
    assign sh     = {hi_r[WIDTH-1:0], lo_r[WIDTH-1]};
    assign diff   = {1'b0, sh} - {2'b00, b_r};
    assign borrow = diff[WIDTH+1];

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_r <= '0;
            lo_r <= '0;
            b_r  <= '0;
        end else if (load) begin
            hi_r <= '0;
            lo_r <= a_in;
            b_r  <= b_in;
        end else if (step) begin
            if (sub) begin
                hi_r <= borrow ? sh : diff[WIDTH:0];
                lo_r <= {lo_r[WIDTH-2:0], ~borrow};
            end else begin
                hi_r <= {1'b0, sum[WIDTH:1]};
                lo_r <= {sum[0], lo_r[WIDTH-1:1]};
            end
        end
    end

    assign hi = hi_r[WIDTH-1:0];
    assign lo = lo_r;

endmodule

// File: rtl/mdu_seq_ctrl.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall.
// Ports: clk, reset (sync, high), start/op/S/T request; busy, stall, done,
// Y_Hi/Y_Lo results, N/Z/V flags. Optional MDU_EARLY_OUT_EN: multiply exits
// once the remaining multiplier bits are zero.
module mdu_seq_ctrl #(
    parameter int WIDTH = mdu_pkg::MDU_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] T,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] Y_Hi,
    output logic [WIDTH-1:0] Y_Lo,
    output logic             N,
    output logic             Z,
    output logic             V
);

    import mdu_pkg::*;

    state_t           state;
    logic [1:0]       op_r;
    logic             neg_res;
    logic             neg_rem;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_v;

    logic             idle;
    logic             accept;
    logic             op_div;
    logic             op_sgn;
    logic             r_div;
    logic             s_neg;
    logic             t_neg;
    logic [WIDTH-1:0] s_mag;
    logic [WIDTH-1:0] t_mag;
    logic [WIDTH-1:0] c_hi;
    logic [WIDTH-1:0] c_lo;
    logic             step;
    logic             last;
    logic             early;
    logic             early_idle;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rmd;

    assign idle   = (state == IDLE);
    assign accept = idle & start;
    assign stall  = busy | accept;

    assign op_div = (op == OP_DIV) || (op == OP_DIVU);
    assign op_sgn = (op == OP_MULT) || (op == OP_DIV);
    assign r_div  = (op_r == OP_DIV) || (op_r == OP_DIVU);

    assign s_neg = op_sgn & S[WIDTH-1];
    assign t_neg = op_sgn & T[WIDTH-1];
    assign s_mag = s_neg ? -S : S;
    assign t_mag = t_neg ? -T : T;

    assign last = (cnt == CNT_W'(WIDTH - 1));

`ifdef MDU_EARLY_OUT_EN
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   m_left;
    logic [CNT_W-1:0]   n_left;
    logic [2*WIDTH-1:0] full;

    // After cnt steps the low WIDTH-cnt bits of lo are the multiplier bits
    // not yet consumed. Leave once at most bit 0 of them remains; that last
    // partial product and the outstanding shift are folded into FIX.
    assign n_left     = CNT_W'(WIDTH) - cnt;
    assign m_left     = c_lo & ({WIDTH{1'b1}} >> cnt);
    assign early      = !r_div && (m_left[WIDTH-1:1] == '0);
    assign early_idle = !op_div && (t_mag[WIDTH-1:1] == '0);
    assign full       = {c_hi, c_lo};
    assign prod       = (full >> n_left)
                      + (m_left[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0);
`else
    assign early      = 1'b0;
    assign early_idle = 1'b0;
    assign prod       = {c_hi, c_lo};
`endif

    assign step = (state == CALC) & !early;

    assign prod_s = neg_res ? -prod : prod;
    assign quot   = neg_res ? -c_lo : c_lo;
    assign rmd    = neg_rem ? -c_hi : c_hi;

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .step  (step),
        .sub   (r_div),
        .a_in  (op_div ? s_mag : t_mag),
        .b_in  (op_div ? t_mag : s_mag),
        .hi    (c_hi),
        .lo    (c_lo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_r    <= OP_MULT;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            cnt     <= '0;
            res_hi  <= '0;
            res_lo  <= '0;
            res_v   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Y_Hi    <= '0;
            Y_Lo    <= '0;
            N       <= 1'b0;
            Z       <= 1'b1;
            V       <= 1'b0;
`ifdef MDU_EARLY_OUT_EN
            mcand   <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        op_r    <= op;
                        neg_res <= s_neg ^ t_neg;
                        neg_rem <= s_neg;
                        cnt     <= '0;
                        busy    <= 1'b1;
`ifdef MDU_EARLY_OUT_EN
                        mcand   <= s_mag;
`endif
                        // HI keeps the raw dividend on a zero divisor.
                        if (op_div && T == '0) begin
                            res_hi <= S;
                            res_lo <= DIV0_QUOT;
                            res_v  <= 1'b1;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else if (early_idle) begin
                            state <= FIX;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (early) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (last) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (r_div) begin
                        res_hi <= rmd;
                        res_lo <= quot;
                    end else begin
                        res_hi <= prod_s[2*WIDTH-1:WIDTH];
                        res_lo <= prod_s[WIDTH-1:0];
                    end
                    res_v <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    Y_Hi  <= res_hi;
                    Y_Lo  <= res_lo;
                    N     <= r_div ? res_lo[WIDTH-1] : res_hi[WIDTH-1];
                    Z     <= ((res_hi | res_lo) == '0);
                    V     <= res_v;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
